// File: rtl/fa_serial_arbiter_if.sv
// Bus between the two requesters, the shared full-adder cell and the
// serial arbiter. The arbiter connects through the slave modport and
// the environment through the master modport.
//
// Handshake: a requester raises reqN and holds its operands. gntN is a
// single-cycle pulse that appears only while the arbiter is idle. The
// operands must be valid in the cycle gntN is high and may change on
// the following cycle. The result appears on sum/cout/owner in the cycle
// done pulses and stays there until the next done pulse.
interface fa_serial_arbiter_if #(
  parameter int W = 8
);
  // Requester side
  logic         req0;
  logic         req1;
  logic [W-1:0] a0;
  logic [W-1:0] a1;
  logic [W-1:0] b0;
  logic [W-1:0] b1;
  logic         cin0;
  logic         cin1;
  logic         gnt0;
  logic         gnt1;

  // Shared full-adder cell
  logic         fa_a;
  logic         fa_b;
  logic         fa_cin;
  logic         fa_sum;
  logic         fa_cout;

  // Result
  logic [W-1:0] sum;
  logic         cout;
  logic         owner;
  logic         done;

  // FSM state, for observation only
  logic [1:0]   dbg_state;

  modport slave (
    input  req0, req1, a0, a1, b0, b1, cin0, cin1, fa_sum, fa_cout,
    output gnt0, gnt1, fa_a, fa_b, fa_cin, sum, cout, owner, done,
    output dbg_state
  );

  modport master (
    output req0, req1, a0, a1, b0, b1, cin0, cin1, fa_sum, fa_cout,
    input  gnt0, gnt1, fa_a, fa_b, fa_cin, sum, cout, owner, done,
    input  dbg_state
  );
endinterface

// File: rtl/fa_serial_arbiter.sv
// Two-requester round-robin arbiter in front of one bit-serial adder.
// The winner's operands are captured once and then added LSB-first over
// W cycles, using one external full-adder cell for every bit. The result
// is published together with the id of the requester that owns it.
module fa_serial_arbiter #(
  parameter int W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  fa_serial_arbiter_if.slave     bus
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e        state_q,     state_d;
  logic [CW-1:0] cnt_q,       cnt_d;
  logic [W-1:0]  a_shift_q,   a_shift_d;
  logic [W-1:0]  b_shift_q,   b_shift_d;
  logic [W-1:0]  sum_shift_q, sum_shift_d;
  logic          carry_q,     carry_d;
  logic          id_q,        id_d;
  logic          rr_q,        rr_d;
  logic [W-1:0]  sum_q,       sum_d;
  logic          cout_q,      cout_d;
  logic          owner_q,     owner_d;
  logic          done_q,      done_d;

  logic          any_req;
  logic          win_id;
  logic          grant;
  logic          in_run;
  logic [W-1:0]  sum_final;

  // Round-robin choice: on a tie the requester not served last wins,
  // otherwise the single requester wins.
  always_comb begin
    win_id = bus.req1;
    if (bus.req0 && bus.req1) begin
      win_id = ~rr_q;
    end
  end

  assign any_req = bus.req0 | bus.req1;
  // Grants are gated by rst_n so they stay low for the whole reset.
  assign grant   = rst_n && (state_q == S_IDLE) && any_req;

  assign bus.gnt0 = grant & ~win_id;
  assign bus.gnt1 = grant &  win_id;

  // The adder cell sees the current operand bits only while running;
  // everywhere else it is held at zero.
  assign in_run     = (state_q == S_RUN);
  assign bus.fa_a   = in_run & a_shift_q[0];
  assign bus.fa_b   = in_run & b_shift_q[0];
  assign bus.fa_cin = in_run & carry_q;

  // Sum register contents after this cycle's bit has been shifted in;
  // on the last RUN cycle this is the finished sum.
  assign sum_final = {bus.fa_sum, sum_shift_q[W-1:1]};

  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.owner     = owner_q;
  assign bus.done      = done_q;
  assign bus.dbg_state = state_q;

  // Next-state and datapath update for the arbitrate/run/publish sequence.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_shift_d   = a_shift_q;
    b_shift_d   = b_shift_q;
    sum_shift_d = sum_shift_q;
    carry_d     = carry_q;
    id_d        = id_q;
    rr_d        = rr_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    owner_d     = owner_q;
    done_d      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (grant) begin
          // Operands are only guaranteed in the grant cycle, so take
          // a full copy of the winner's inputs here.
          a_shift_d = win_id ? bus.a1   : bus.a0;
          b_shift_d = win_id ? bus.b1   : bus.b0;
          carry_d   = win_id ? bus.cin1 : bus.cin0;
          id_d      = win_id;
          rr_d      = win_id;
          cnt_d     = '0;
          state_d   = S_RUN;
        end
      end

      S_RUN: begin
        a_shift_d   = a_shift_q >> 1;
        b_shift_d   = b_shift_q >> 1;
        sum_shift_d = sum_final;
        carry_d     = bus.fa_cout;
        cnt_d       = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          // W bits done: publish the result and pulse done next cycle.
          state_d = S_DONE;
          sum_d   = sum_final;
          cout_d  = bus.fa_cout;
          owner_d = id_q;
          done_d  = 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; reset aborts any operation in flight and points
  // the round-robin pointer at requester 1 so requester 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      a_shift_q   <= '0;
      b_shift_q   <= '0;
      sum_shift_q <= '0;
      carry_q     <= 1'b0;
      id_q        <= 1'b0;
      rr_q        <= 1'b1;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      owner_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_shift_q   <= a_shift_d;
      b_shift_q   <= b_shift_d;
      sum_shift_q <= sum_shift_d;
      carry_q     <= carry_d;
      id_q        <= id_d;
      rr_q        <= rr_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      owner_q     <= owner_d;
      done_q      <= done_d;
    end
  end

endmodule
